// File: rtl/alu_pkg.sv
// Shared types for the mode-selected ALU pipeline.
//   alu_mode_e  : operation select carried through the pipeline
//   alu_cat_e   : magnitude class of the result
//   decode_mode : folds the raw 3-bit mode onto the enum (110/111 alias XOR)
package alu_pkg;

    typedef enum logic [2:0] {
        MODE_XOR    = 3'b000,
        MODE_ADDSUB = 3'b001,
        MODE_SUB    = 3'b010,
        MODE_MULDIV = 3'b011,
        MODE_MAX    = 3'b100,
        MODE_MIN    = 3'b101
    } alu_mode_e;

    typedef enum logic [1:0] {
        CAT_LOW  = 2'd0,
        CAT_MID  = 2'd1,
        CAT_HIGH = 2'd2,
        CAT_TOP  = 2'd3
    } alu_cat_e;

    function automatic alu_mode_e decode_mode(input logic [2:0] raw);
        alu_mode_e m;
        case (raw)
            3'b000:  m = MODE_XOR;
            3'b001:  m = MODE_ADDSUB;
            3'b010:  m = MODE_SUB;
            3'b011:  m = MODE_MULDIV;
            3'b100:  m = MODE_MAX;
            3'b101:  m = MODE_MIN;
            default: m = MODE_XOR;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mode_alu_pipe_if.sv
// Operand/result bundle for mode_alu_pipe.
//   master : operand source + result consumer (drives in_valid/a/b/mode/out_ready)
//   slave  : the pipeline (drives in_ready and all result signals)
interface mode_alu_pipe_if #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2:0]         mode;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   res;
    logic [WIDTH:0]     diff;
    logic [1:0]         category;
    logic               div_zero;
    logic [COUNT_W-1:0] op_count;

    modport master (
        output in_valid, a, b, mode, out_ready,
        input  in_ready, out_valid, res, diff, category, div_zero, op_count
    );

    modport slave (
        input  in_valid, a, b, mode, out_ready,
        output in_ready, out_valid, res, diff, category, div_zero, op_count
    );
endinterface

// File: rtl/mode_alu_core.sv
// Combinational mode ALU. Works from operands already staged in S1, so the
// compares and the zero-safe divisor arrive precomputed.
//   a, b     : operands
//   div_b    : divisor with 0 replaced by 1
//   mode     : decoded operation
//   a_lt_b / a_gt_b / b_zero : staged compare results
//   res      : mode result (mod 2^WIDTH)
//   div_zero : divide path taken with b == 0
module mode_alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] div_b,
    input  alu_mode_e        mode,
    input  logic             a_lt_b,
    input  logic             a_gt_b,
    input  logic             b_zero,
    output logic [WIDTH-1:0] res,
    output logic             div_zero
);

    // Result mux over the operation modes.
    always_comb begin
        res      = a ^ b;
        div_zero = 1'b0;
        case (mode)
            MODE_XOR: begin
                res = a ^ b;
            end
            MODE_ADDSUB: begin
                if (a_gt_b) begin
                    res = a + b;
                end else begin
                    res = a - b;
                end
            end
            MODE_SUB: begin
                res = a - b;
            end
            MODE_MULDIV: begin
                if (a_lt_b) begin
                    res = a * b;                 // low WIDTH bits of the product
                end else begin
                    res      = a / div_b;
                    div_zero = b_zero;           // a >= b holds trivially when b == 0
                end
            end
            MODE_MAX: begin
                if (a_gt_b) begin
                    res = a;
                end else if (a_lt_b) begin
                    res = b;
                end else begin
                    res = a + b;                 // equal operands
                end
            end
            MODE_MIN: begin
                if (a_lt_b) begin
                    res = a;
                end else begin
                    res = b;
                end
            end
            default: begin
                res = a ^ b;
            end
        endcase
    end

endmodule

// File: rtl/mode_alu_pipe.sv
// Two-stage pipelined mode ALU with valid/ready on both sides.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : mode_alu_pipe_if.slave (operands in, results out, op_count)
// S1 stages operands, decoded mode, compares and the zero-safe divisor.
// S2 holds res/diff/category/div_zero and drives the outputs directly.
module mode_alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 16,
    parameter int T0      = 10,
    parameter int T1      = 50,
    parameter int T2      = 100
) (
    input logic            clk,
    input logic            rst,
    mode_alu_pipe_if.slave bus
);

    localparam logic [WIDTH-1:0] T0_C  = WIDTH'(T0);
    localparam logic [WIDTH-1:0] T1_C  = WIDTH'(T1);
    localparam logic [WIDTH-1:0] T2_C  = WIDTH'(T2);
    localparam logic [WIDTH-1:0] ONE_C = {{(WIDTH-1){1'b0}}, 1'b1};

    logic               s1_valid_r, s2_valid_r;
    logic [WIDTH-1:0]   s1_a_r, s1_b_r, s1_div_b_r;
    alu_mode_e          s1_mode_r;
    logic               s1_lt_r, s1_gt_r, s1_bz_r;
    logic [WIDTH-1:0]   res_r;
    logic [WIDTH:0]     diff_r;
    alu_cat_e           cat_r;
    logic               dz_r;
    logic [COUNT_W-1:0] op_count_r;

    logic               s2_load_s, in_ready_s, accept_s;
    logic [WIDTH-1:0]   core_res_s;
    logic               core_dz_s;
    logic [WIDTH:0]     diff_s;
    alu_cat_e           cat_s;

    // in_ready depends only on stage valids and out_ready, never on in_valid.
    assign s2_load_s  = !s2_valid_r || bus.out_ready;
    assign in_ready_s = !s1_valid_r || s2_load_s;
    assign accept_s   = bus.in_valid && in_ready_s;

    mode_alu_core #(.WIDTH(WIDTH)) u_core (
        .a        (s1_a_r),
        .b        (s1_b_r),
        .div_b    (s1_div_b_r),
        .mode     (s1_mode_r),
        .a_lt_b   (s1_lt_r),
        .a_gt_b   (s1_gt_r),
        .b_zero   (s1_bz_r),
        .res      (core_res_s),
        .div_zero (core_dz_s)
    );

    assign diff_s = {1'b0, s1_a_r} - {1'b0, s1_b_r};

    // Magnitude class of the result against the three thresholds.
    always_comb begin
        if (core_res_s < T0_C) begin
            cat_s = CAT_LOW;
        end else if (core_res_s < T1_C) begin
            cat_s = CAT_MID;
        end else if (core_res_s < T2_C) begin
            cat_s = CAT_HIGH;
        end else begin
            cat_s = CAT_TOP;
        end
    end

    // Stage 1: capture an accepted beat with its decode and compares.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_a_r     <= '0;
            s1_b_r     <= '0;
            s1_div_b_r <= ONE_C;
            s1_mode_r  <= MODE_XOR;
            s1_lt_r    <= 1'b0;
            s1_gt_r    <= 1'b0;
            s1_bz_r    <= 1'b0;
        end else if (in_ready_s) begin
            s1_valid_r <= bus.in_valid;
            if (bus.in_valid) begin
                s1_a_r     <= bus.a;
                s1_b_r     <= bus.b;
                s1_div_b_r <= (bus.b == '0) ? ONE_C : bus.b;
                s1_mode_r  <= decode_mode(bus.mode);
                s1_lt_r    <= (bus.a < bus.b);
                s1_gt_r    <= (bus.a > bus.b);
                s1_bz_r    <= (bus.b == '0);
            end
        end
    end

    // Stage 2: result registers; frozen while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            res_r      <= '0;
            diff_r     <= '0;
            cat_r      <= CAT_LOW;
            dz_r       <= 1'b0;
        end else if (s2_load_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                res_r  <= core_res_s;
                diff_r <= diff_s;
                cat_r  <= cat_s;
                dz_r   <= core_dz_s;
            end
        end
    end

    // Accepted-beat counter, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count_r <= '0;
        end else if (accept_s) begin
            op_count_r <= op_count_r + {{(COUNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = s2_valid_r;
    assign bus.res       = res_r;
    assign bus.diff      = diff_r;
    assign bus.category  = cat_r;
    assign bus.div_zero  = dz_r;
    assign bus.op_count  = op_count_r;

endmodule
